// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, FSM state encoding and the default
// alignment parameters. Kept free of decoder-only detail so the encoder can reuse it.
package tmds_pkg;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    localparam int LOCK_TOKENS_DEF   = 64;
    localparam int SEARCH_WINDOW_DEF = 1024;
    localparam int SLIP_WAIT_DEF     = 16;
    localparam int RELOCK_RUN_DEF    = 8;

    typedef logic [1:0] tmds_state_t;

    localparam tmds_state_t ST_SEARCH = 2'd0;
    localparam tmds_state_t ST_SLIP   = 2'd1;
    localparam tmds_state_t ST_WAIT   = 2'd2;
    localparam tmds_state_t ST_LOCKED = 2'd3;

endpackage

// File: rtl/tmds_decoder_if.sv
// Symbol stream from the deserializer plus the decoded video/alignment outputs.
// The master side feeds words and watches bitslip; the slave side is the decoder.
interface tmds_decoder_if;

    logic [9:0] tmds_word;
    logic       bitslip;
    logic       locked;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic       err;

    modport master (
        output tmds_word,
        input  bitslip, locked, de, ctrl, data, err
    );

    modport slave (
        input  tmds_word,
        output bitslip, locked, de, ctrl, data, err
    );

endinterface

// File: rtl/tmds_symbol_decode.sv
// Purely combinational decode of one 10-bit TMDS symbol into either a control
// pair or a data byte. Data is always computed; is_ctrl tells which one counts.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] tmds_word,
    output logic       is_ctrl,
    output logic [1:0] ctrl,
    output logic [7:0] data
);

    logic [9:0] w_q;

    // Match the four control tokens, then undo the optional inversion and XOR/XNOR chain
    always_comb begin
        is_ctrl = 1'b1;
        ctrl    = 2'b00;
        case (tmds_word)
            CTRL_TOKEN_00: ctrl = 2'b00;
            CTRL_TOKEN_01: ctrl = 2'b01;
            CTRL_TOKEN_10: ctrl = 2'b10;
            CTRL_TOKEN_11: ctrl = 2'b11;
            default:       is_ctrl = 1'b0;
        endcase

        w_q     = tmds_word[9] ? {tmds_word[9:8], ~tmds_word[7:0]} : tmds_word;
        data    = 8'h00;
        data[0] = w_q[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = w_q[8] ? (w_q[i] ^ w_q[i-1]) : ~(w_q[i] ^ w_q[i-1]);
        end
    end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: registers the incoming symbol, hunts for word alignment
// by counting control-token runs and pulsing bitslip, and once locked presents
// de/ctrl/data two cycles after the symbol arrives.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS   = LOCK_TOKENS_DEF,
    parameter int SEARCH_WINDOW = SEARCH_WINDOW_DEF,
    parameter int SLIP_WAIT     = SLIP_WAIT_DEF,
    parameter int RELOCK_RUN    = RELOCK_RUN_DEF
)
(
    input  logic          pixclk,
    input  logic          rst,
    tmds_decoder_if.slave bus
);

    localparam int                RUN_W     = $clog2(LOCK_TOKENS + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(LOCK_TOKENS);
    localparam logic [RUN_W-1:0]  RELOCK    = RUN_W'(RELOCK_RUN);
    localparam int                WIN_W     = $clog2(SEARCH_WINDOW + 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [WIN_W-1:0]  WIN_MAX   = WIN_W'(SEARCH_WINDOW);
    localparam int                WAIT_W    = $clog2(SLIP_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
    localparam logic [3:0]        SLIP_LAST = 4'd9;

    logic [9:0]        r_word;
    tmds_state_t       r_state;
    logic [RUN_W-1:0]  r_runCnt;
    logic [WIN_W-1:0]  r_winCnt;
    logic [WIN_W-1:0]  r_wdogCnt;
    logic [WAIT_W-1:0] r_waitCnt;
    logic [3:0]        r_slipCnt;
    logic              r_err;
    logic              r_de;
    logic [1:0]        r_ctrl;
    logic [7:0]        r_data;

    logic              w_isCtrl;
    logic [1:0]        w_ctrl;
    logic [7:0]        w_data;
    logic [RUN_W-1:0]  w_runNext;
    logic [WIN_W-1:0]  w_winInc;
    logic [WIN_W-1:0]  w_wdogInc;

    tmds_symbol_decode u_decode (
        .tmds_word (r_word),
        .is_ctrl   (w_isCtrl),
        .ctrl      (w_ctrl),
        .data      (w_data)
    );

    // Saturating next values for the run, window and watchdog counters
    always_comb begin
        w_runNext = '0;
        if (w_isCtrl) begin
            w_runNext = (r_runCnt == RUN_MAX) ? r_runCnt : r_runCnt + 1'b1;
        end
        w_winInc  = (r_winCnt  == WIN_MAX) ? r_winCnt  : r_winCnt  + 1'b1;
        w_wdogInc = (r_wdogCnt == WIN_MAX) ? r_wdogCnt : r_wdogCnt + 1'b1;
    end

    // Alignment FSM: search for a token run, slip and settle, or watch a held lock
    always_ff @(posedge pixclk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_SEARCH;
            r_runCnt  <= '0;
            r_winCnt  <= '0;
            r_wdogCnt <= '0;
            r_waitCnt <= '0;
            r_slipCnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_SEARCH: begin
                    r_runCnt <= w_runNext;
                    r_winCnt <= w_winInc;
                    if (w_runNext == RUN_MAX) begin
                        r_state   <= ST_LOCKED;
                        r_slipCnt <= '0;
                        r_runCnt  <= '0;
                        r_winCnt  <= '0;
                        r_wdogCnt <= '0;
                    end else if (r_winCnt == WIN_LAST) begin
                        r_state <= ST_SLIP;
                    end
                end
                ST_SLIP: begin
                    r_slipCnt <= (r_slipCnt == SLIP_LAST) ? 4'd0 : r_slipCnt + 1'b1;
                    r_err     <= (r_slipCnt == SLIP_LAST);
                    r_waitCnt <= '0;
                    r_state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_waitCnt == WAIT_LAST) begin
                        r_state  <= ST_SEARCH;
                        r_runCnt <= '0;
                        r_winCnt <= '0;
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (r_wdogCnt == WIN_MAX) begin
                        r_state   <= ST_SEARCH;
                        r_runCnt  <= '0;
                        r_winCnt  <= '0;
                        r_wdogCnt <= '0;
                    end else begin
                        r_runCnt <= w_runNext;
                        if (w_runNext >= RELOCK) begin
                            r_wdogCnt <= '0;
                        end else begin
                            r_wdogCnt <= w_wdogInc;
                            r_err     <= (w_wdogInc == WIN_MAX);
                        end
                    end
                end
                default: r_state <= ST_SEARCH;
            endcase
        end
    end

    // Input register and decoded output register; outputs stay blank unless locked
    always_ff @(posedge pixclk or negedge rst) begin
        if (!rst) begin
            r_word <= '0;
            r_de   <= 1'b0;
            r_ctrl <= 2'b00;
            r_data <= 8'h00;
        end else begin
            r_word <= bus.tmds_word;
            if (r_state == ST_LOCKED) begin
                if (w_isCtrl) begin
                    r_de   <= 1'b0;
                    r_data <= 8'h00;
                    r_ctrl <= w_ctrl;
                end else begin
                    r_de   <= 1'b1;
                    r_data <= w_data;
                end
            end else begin
                r_de   <= 1'b0;
                r_data <= 8'h00;
                r_ctrl <= 2'b00;
            end
        end
    end

    assign bus.bitslip = (r_state == ST_SLIP);
    assign bus.locked  = (r_state == ST_LOCKED);
    assign bus.de      = r_de;
    assign bus.ctrl    = r_ctrl;
    assign bus.data    = r_data;
    assign bus.err     = r_err;

endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: alignment, lock, data/control decode, watchdog
// loss of lock, slip rotation wrap and asynchronous reset behaviour.
module tb_tmds_decoder;

    logic pixclk = 1'b0;
    logic rst    = 1'b1;

    tmds_decoder_if bus ();

    tmds_decoder dut (
        .pixclk (pixclk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 pixclk = ~pixclk;

    int cyc = 0;

    always @(posedge pixclk) begin
        cyc <= cyc + 1;
    end

    typedef struct {
        int         due;
        int         idx;
        logic       de;
        logic [1:0] ctrl;
        logic [7:0] data;
    } exp_t;

    exp_t sbq[$];
    exp_t monExp;
    int   pushIdx     = 0;
    int   testsRun    = 0;
    int   testsFailed = 0;

    logic sBitslip, sLocked, sErr, sDe;
    int   sCyc;

    // Pop one expected output when its cycle comes up and compare it against the outputs
    always @(negedge pixclk) begin
        if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            monExp = sbq.pop_front();
            testsRun++;
            if (bus.de !== monExp.de || bus.ctrl !== monExp.ctrl || bus.data !== monExp.data) begin
                testsFailed++;
                $display("[TB] FAIL sb_word%0d: de/ctrl/data got %0b/%b/%02h, expected %0b/%b/%02h",
                         monExp.idx, bus.de, bus.ctrl, bus.data, monExp.de, monExp.ctrl, monExp.data);
            end
        end
    end

    // Hard stop in case something wedges the stimulus
    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkAllClear(input string tag);
        checkOutput({tag, "_bitslip"}, 32'(bus.bitslip), 0);
        checkOutput({tag, "_locked"},  32'(bus.locked),  0);
        checkOutput({tag, "_de"},      32'(bus.de),      0);
        checkOutput({tag, "_ctrl"},    32'(bus.ctrl),    0);
        checkOutput({tag, "_data"},    32'(bus.data),    0);
        checkOutput({tag, "_err"},     32'(bus.err),     0);
    endtask

    // Drive one word for one cycle, optionally queueing its expected output two cycles later
    task automatic applyStimulus(input logic [9:0] word, input bit doPush,
                                 input logic eDe, input logic [1:0] eCtrl, input logic [7:0] eData);
        exp_t e;
        bus.tmds_word = word;
        if (doPush) begin
            e.due  = cyc + 2;
            e.idx  = pushIdx;
            e.de   = eDe;
            e.ctrl = eCtrl;
            e.data = eData;
            sbq.push_back(e);
            pushIdx++;
        end
        @(negedge pixclk);
        sBitslip = bus.bitslip;
        sLocked  = bus.locked;
        sErr     = bus.err;
        sDe      = bus.de;
        sCyc     = cyc;
        @(posedge pixclk);
        #1;
    endtask

    task automatic driveWord(input logic [9:0] word);
        applyStimulus(word, 1'b0, 1'b0, 2'b00, 8'h00);
    endtask

    task automatic applyReset();
        rst           = 1'b0;
        bus.tmds_word = '0;
        repeat (3) @(posedge pixclk);
        #1;
        rst = 1'b1;
    endtask

    // Deserializer misaligned by m bits on a periodic token stream
    function automatic logic [9:0] rotWord(input logic [9:0] t, input int m);
        logic [9:0] w;
        for (int i = 0; i < 10; i++) begin
            w[i] = t[(i + m) % 10];
        end
        return w;
    endfunction

    localparam logic [9:0] TOK00 = 10'b1101010100;

    // Post-lock words with hand-decoded de/ctrl/data
    logic [9:0] dWord [11] = '{10'h100, 10'h1FF, 10'h200, 10'h101, 10'h055, 10'h30F,
                               10'h2AB, 10'h0AB, 10'h1FF, 10'h154, 10'h200};
    logic       dDe   [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0] dCtrl [11] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                               2'b11, 2'b01, 2'b01, 2'b10, 2'b10};
    logic [7:0] dData [11] = '{8'h00, 8'h01, 8'hFF, 8'h03, 8'h01, 8'h10,
                               8'h00, 8'h00, 8'h01, 8'h00, 8'hFF};

    int c0, errCnt, errCyc, slips, lastSlip, tenthCyc, mis;
    bit gotLock, lockSeen;

    initial begin
        bus.tmds_word = '0;
        #2 rst = 1'b0;
        @(negedge pixclk);
        checkAllClear("reset");
        @(posedge pixclk);
        #1 rst = 1'b1;

        // Aligned blanking, then data and control words once locked
        c0 = cyc;
        for (int j = 0; j < 64; j++) begin
            applyStimulus(TOK00, 1'b1, 1'b0, 2'b00, 8'h00);
        end
        for (int k = 0; k < 11; k++) begin
            applyStimulus(dWord[k], 1'b1, dDe[k], dCtrl[k], dData[k]);
            if (k == 0) checkOutput("locked_before_64th", 32'(sLocked), 0);
            if (k == 1) checkOutput("locked_after_64th",  32'(sLocked), 1);
        end

        // Data-only input until the watchdog gives up the lock
        errCnt = 0;
        errCyc = -1;
        for (int i = 0; i < 1100; i++) begin
            driveWord(10'h100);
            if (sErr) begin
                errCnt++;
                errCyc = sCyc;
            end
        end
        checkOutput("wdog_err_count", errCnt, 1);
        checkOutput("wdog_err_cycle", errCyc, c0 + 1089);
        checkOutput("wdog_locked",    32'(sLocked), 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(10'h200, 1'b1, 1'b0, 2'b00, 8'h00);
        end

        // Relock, show live outputs, then pull reset while locked
        for (int i = 0; i < 66; i++) driveWord(TOK00);
        checkOutput("relocked", 32'(sLocked), 1);
        driveWord(10'h2AB);
        applyStimulus(10'h101, 1'b1, 1'b1, 2'b11, 8'h03);
        driveWord(10'h200);
        driveWord(10'h200);
        checkOutput("de_before_rst", 32'(sDe), 1);
        rst = 1'b0;
        #1;
        checkAllClear("rst_locked");
        repeat (3) @(posedge pixclk);
        #1 rst = 1'b1;

        // Stream rotated by 3 bits; each bitslip walks the model one bit back
        applyReset();
        mis      = 3;
        slips    = 0;
        lastSlip = -1;
        gotLock  = 1'b0;
        for (int i = 0; i < 6000 && !gotLock; i++) begin
            driveWord(rotWord(TOK00, mis));
            if (sBitslip) begin
                slips++;
                if (lastSlip >= 0) begin
                    testsRun++;
                    if (sCyc - lastSlip < 1040) begin
                        testsFailed++;
                        $display("[TB] FAIL misalign_spacing: got %0d cycles, expected at least 1040", sCyc - lastSlip);
                    end
                end
                lastSlip = sCyc;
                mis      = (mis + 9) % 10;
            end
            if (sLocked) gotLock = 1'b1;
        end
        checkOutput("misalign_locked", 32'(gotLock), 1);
        checkOutput("misalign_slips",  slips, 3);

        // Garbage only: periodic slips, one err on the tenth, never locks
        applyReset();
        slips    = 0;
        lastSlip = -1;
        tenthCyc = -1;
        errCnt   = 0;
        errCyc   = -1;
        lockSeen = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            driveWord(10'h155);
            if (sBitslip) begin
                slips++;
                if (lastSlip >= 0) checkOutput("garbage_spacing", sCyc - lastSlip, 1041);
                lastSlip = sCyc;
                if (slips == 10) tenthCyc = sCyc;
            end
            if (sErr) begin
                errCnt++;
                errCyc = sCyc;
            end
            if (sLocked) lockSeen = 1'b1;
            if (tenthCyc >= 0 && sCyc >= tenthCyc + 5) break;
        end
        checkOutput("garbage_slips",     slips, 10);
        checkOutput("garbage_err_count", errCnt, 1);
        checkOutput("garbage_err_cycle", errCyc, tenthCyc + 1);
        checkOutput("garbage_locked",    32'(lockSeen), 0);

        // Still settling after the tenth slip: reset must clear everything at once
        rst = 1'b0;
        #1;
        checkAllClear("rst_wait");
        for (int i = 0; i < 3; i++) begin
            driveWord(10'h155);
            checkOutput("rst_wait_no_slip", 32'(sBitslip), 0);
        end
        rst = 1'b1;

        checkOutput("sb_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
